// File: rtl/div32_seq_pkg.sv
// Shared definitions for the sequential divider: state encoding, default
// operand width and the iteration-counter width derived from it.
package div32_seq_pkg;

  // Default operand/result width; the divider iterates this many times.
  localparam int DIV_WIDTH = 32;

  // Width of a counter that must hold the values 0 .. width-1.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  localparam int DIV_CNT_W = cnt_width(DIV_WIDTH);

  // Control FSM states. RUN is the only state in which busy is high.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div32_datapath.sv
// Shift/subtract datapath of the restoring divider. Holds the working
// remainder/quotient pair, the latched divisor, the iteration counter and
// the result registers. It is steered entirely by strobes from the FSM.
module div32_datapath
  import div32_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_op,    // accept a new operation (divisor != 0)
  input  logic             step,       // perform one restoring iteration
  input  logic             wr_result,  // commit the final iteration to outputs
  input  logic             wr_dbz,     // commit the divide-by-zero result
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             last_iter,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = cnt_width(WIDTH);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   shifted_s;
  logic [WIDTH:0]   trial_s;
  logic             fits_s;
  logic [WIDTH-1:0] rem_step_s;
  logic [WIDTH-1:0] quo_step_s;

  // One restoring step: shift {rem,quo} left, trial-subtract the divisor in
  // WIDTH+1 bits so divisors above 2^(WIDTH-1) cannot overflow the compare.
  always_comb begin
    shifted_s = {rem_q, quo_q[WIDTH-1]};
    trial_s   = shifted_s - {1'b0, dvs_q};
    fits_s    = ~trial_s[WIDTH];
    if (fits_s) begin
      rem_step_s = trial_s[WIDTH-1:0];
    end else begin
      // Shifted remainder is below the divisor here, so it fits in WIDTH bits.
      rem_step_s = shifted_s[WIDTH-1:0];
    end
    quo_step_s = {quo_q[WIDTH-2:0], fits_s};
  end

  // Next values of the working registers and the iteration counter.
  always_comb begin
    if (load_op) begin
      rem_d = {WIDTH{1'b0}};
      quo_d = dividend;
      dvs_d = divisor;
      cnt_d = {CNT_W{1'b0}};
    end else if (step) begin
      rem_d = rem_step_s;
      quo_d = quo_step_s;
      dvs_d = dvs_q;
      // The counter naturally returns to zero after the final iteration.
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      rem_d = rem_q;
      quo_d = quo_q;
      dvs_d = dvs_q;
      cnt_d = cnt_q;
    end
  end

  // Next values of the result registers; they move only on completion.
  always_comb begin
    if (wr_result) begin
      quotient_d  = quo_step_s;
      remainder_d = rem_step_s;
      dbz_d       = 1'b0;
    end else if (wr_dbz) begin
      quotient_d  = {WIDTH{1'b1}};
      remainder_d = dividend;
      dbz_d       = 1'b1;
    end else begin
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;
    end
  end

  // Datapath state registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      rem_q       <= {WIDTH{1'b0}};
      quo_q       <= {WIDTH{1'b0}};
      dvs_q       <= {WIDTH{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      quotient_q  <= {WIDTH{1'b0}};
      remainder_q <= {WIDTH{1'b0}};
      dbz_q       <= 1'b0;
    end else begin
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign last_iter   = (cnt_q == CNT_W'(WIDTH - 1));
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: rtl/div32_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock with a
// start/busy/done handshake. The FSM here sequences div32_datapath.
module div32_seq
  import div32_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  div_state_e state_q, state_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       load_op_s;
  logic       step_s;
  logic       wr_result_s;
  logic       wr_dbz_s;
  logic       last_iter_s;

  div32_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clock      (clock),
    .reset      (reset),
    .load_op    (load_op_s),
    .step       (step_s),
    .wr_result  (wr_result_s),
    .wr_dbz     (wr_dbz_s),
    .dividend   (dividend),
    .divisor    (divisor),
    .last_iter  (last_iter_s),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  // Next state, datapath strobes and next values of the busy/done flags.
  always_comb begin
    state_d     = state_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    load_op_s   = 1'b0;
    step_s      = 1'b0;
    wr_result_s = 1'b0;
    wr_dbz_s    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (divisor != {WIDTH{1'b0}}) begin
            load_op_s = 1'b1;
            state_d   = ST_RUN;
            busy_d    = 1'b1;
          end else begin
            // Division by zero completes immediately without iterating.
            wr_dbz_s = 1'b1;
            state_d  = ST_DONE;
            done_d   = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // start and operand inputs are ignored while iterating.
        step_s = 1'b1;
        if (last_iter_s) begin
          wr_result_s = 1'b1;
          state_d     = ST_DONE;
          done_d      = 1'b1;
        end else begin
          state_d = ST_RUN;
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control registers: FSM state and the registered busy/done outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_div32_seq.sv
// Self-checking bench for div32_seq: a latency/arithmetic model checked
// every cycle, plus directed operations with hand-computed results.
module tb_div32_seq;

  localparam int W = 32;

  logic         clock;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int tests;
  int fails;
  bit chk_en;

  div32_seq #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an accepted op finishes W cycles later with a/b, a%b.
  logic [W-1:0] m_q, m_r, pend_a, pend_b;
  logic         m_dbz, m_busy, m_done;
  int           cycles_left;

  initial begin
    m_q = '0; m_r = '0; m_dbz = 1'b0; m_busy = 1'b0; m_done = 1'b0;
    cycles_left = 0; pend_a = '0; pend_b = '0;
  end

  always @(posedge clock) begin
    if (reset) begin
      m_q = '0; m_r = '0; m_dbz = 1'b0; m_busy = 1'b0; m_done = 1'b0;
      cycles_left = 0;
    end else begin
      m_done = 1'b0;
      if (cycles_left > 0) begin
        cycles_left--;
        if (cycles_left == 0) begin
          m_q = pend_a / pend_b;
          m_r = pend_a % pend_b;
          m_dbz = 1'b0;
          m_done = 1'b1;
          m_busy = 1'b0;
        end else begin
          m_busy = 1'b1;
        end
      end else if (start) begin
        if (divisor == '0) begin
          m_q = '1;
          m_r = dividend;
          m_dbz = 1'b1;
          m_done = 1'b1;
          m_busy = 1'b0;
        end else begin
          pend_a = dividend;
          pend_b = divisor;
          cycles_left = W;
          m_busy = 1'b1;
        end
      end else begin
        m_busy = 1'b0;
      end
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      check("busy", 64'(busy), 64'(m_busy));
      check("done", 64'(done), 64'(m_done));
      check("quotient", 64'(quotient), 64'(m_q));
      check("remainder", 64'(remainder), 64'(m_r));
      check("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // Present an op for one cycle (cycle 0); returns in cycle 1.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    dividend = a;
    divisor = b;
    tick();
    start = 1'b0;
    dividend = $urandom;
    divisor = $urandom;
  endtask

  // Advance until done is seen (bounded); at = cycle number where seen.
  task automatic wait_done(input int cur, output int at);
    at = cur;
    while (done !== 1'b1 && at < cur + 60) begin
      tick();
      at++;
    end
  endtask

  task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic edbz, input int elat);
    int at;
    start_op(a, b);
    wait_done(1, at);
    check({name, "_latency"}, 64'(at), 64'(elat));
    check({name, "_q"}, 64'(quotient), 64'(eq));
    check({name, "_r"}, 64'(remainder), 64'(er));
    check({name, "_dbz"}, 64'(div_by_zero), 64'(edbz));
  endtask

  initial begin
    int at;
    int dones;
    logic [W-1:0] a, b;
    tests = 0; fails = 0; chk_en = 1'b0;
    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clock);
    #2;
    chk_en = 1'b1;
    check("reset_q", 64'(quotient), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    reset = 1'b0;
    tick();

    directed("d100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
    tick();
    directed("dmax_big", 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, 1'b0, 33);
    directed("dmax_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
    tick();
    directed("d5_9", 32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 33);
    tick();
    directed("dzero", 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1, 1);
    tick();

    // start during RUN is ignored, operands wander.
    start_op(32'd100, 32'd7);
    repeat (9) tick();
    start = 1'b1; dividend = 32'd50; divisor = 32'd5;
    tick();
    start = 1'b0; dividend = $urandom; divisor = $urandom;
    wait_done(11, at);
    check("ignore_latency", 64'(at), 64'd33);
    check("ignore_q", 64'(quotient), 64'd14);
    check("ignore_r", 64'(remainder), 64'd2);
    tick();

    // Reset mid-RUN abandons the op.
    start_op(32'd100, 32'd7);
    repeat (14) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_q", 64'(quotient), 64'd0);
    check("midreset_r", 64'(remainder), 64'd0);
    check("midreset_dbz", 64'(div_by_zero), 64'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    check("midreset_no_done", 64'(dones), 64'd0);
    directed("d9_3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33);
    tick();

    // Back-to-back: start held high, second op accepted from DONE.
    start = 1'b1; dividend = 32'd20; divisor = 32'd6;
    tick();
    wait_done(1, at);
    check("b2b_first_latency", 64'(at), 64'd33);
    check("b2b_first_q", 64'(quotient), 64'd3);
    check("b2b_first_r", 64'(remainder), 64'd2);
    dividend = 32'd45; divisor = 32'd4;
    tick();
    check("b2b_busy_again", 64'(busy), 64'd1);
    start = 1'b0;
    wait_done(34, at);
    check("b2b_second_latency", 64'(at), 64'd66);
    check("b2b_second_q", 64'(quotient), 64'd11);
    check("b2b_second_r", 64'(remainder), 64'd1);

    // Randomized ops, some back-to-back from DONE, some with zero divisor.
    for (int k = 0; k < 150; k++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = '0;
        1: b = W'($urandom_range(1, 15));
        2: b = $urandom | 32'h8000_0000;
        default: b = $urandom;
      endcase
      start_op(a, b);
      wait_done(1, at);
      if (b == '0) begin
        check("rand_latency", 64'(at), 64'd1);
        check("rand_q", 64'(quotient), 64'hFFFF_FFFF);
        check("rand_r", 64'(remainder), 64'(a));
      end else begin
        check("rand_latency", 64'(at), 64'd33);
        check("rand_q", 64'(quotient), 64'(a / b));
        check("rand_r", 64'(remainder), 64'(a % b));
      end
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
